// File: rtl/vga_text_scheduler.sv
// Fills the 12x13 character text RAM with "CHnn: d.dddV" rows, one per channel, once per vblank rise.
// Latency: 27 cycles per row with immediate ack (1 fetch + 14 convert + 12 write), +1 DONE cycle per pass.
// Backpressure: ch_req is held until ch_ack; VGA_TEXT_OVR_EN shows "-.---" for over-range values instead of clamping.
module vga_text_scheduler #(
    parameter int CHANNELS = 13,
    parameter int COLS     = 12,
    parameter int VAL_MAX  = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk_in,
    output logic [3:0]  ch_sel,
    output logic        ch_req,
    input  logic        ch_ack,
    input  logic [13:0] ch_value,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [6:0]  wr_data,
    output logic        busy,
    output logic        frame_done
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CONVERT, S_WRITE, S_DONE} state_t;

    localparam logic [13:0] VMAX     = 14'(VAL_MAX);
    localparam logic [3:0]  LAST_ROW = 4'(CHANNELS - 1);
    localparam logic [3:0]  LAST_BIT = 4'd13;
    localparam logic [3:0]  NCOLS    = 4'(COLS);

    state_t      state_q, state_d;
    logic        vblnk_prev_q, vblnk_prev_d;
    logic        pending_q, pending_d;
    logic [3:0]  row_q, row_d;
    logic [13:0] val_q, val_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  col_q, col_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  ch_sel_q, ch_sel_d;
    logic        ch_req_q, ch_req_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [6:0]  wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
`ifdef VGA_TEXT_OVR_EN
    logic        ovr_q, ovr_d;
`endif

    logic        rise;
    logic [15:0] bcd_adj;
    logic [6:0]  char_nxt;
    logic [7:0]  row_base;

    always_comb begin
        state_d      = state_q;
        vblnk_prev_d = vblnk_in;
        pending_d    = pending_q;
        row_d        = row_q;
        val_d        = val_q;
        bcd_d        = bcd_q;
        bit_cnt_d    = bit_cnt_q;
        col_d        = col_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        ch_sel_d     = ch_sel_q;
        ch_req_d     = ch_req_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
`ifdef VGA_TEXT_OVR_EN
        ovr_d        = ovr_q;
`endif
        rise     = vblnk_in & ~vblnk_prev_q;
        row_base = {4'b0000, row_q} * 8'(COLS);

        // Double-dabble: add 3 to every BCD digit >= 5 before the shift.
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (col_q)
            4'd0:    char_nxt = 7'h43;
            4'd1:    char_nxt = 7'h48;
            4'd2:    char_nxt = 7'h30 + {3'b000, tens_q};
            4'd3:    char_nxt = 7'h30 + {3'b000, ones_q};
            4'd4:    char_nxt = 7'h3A;
            4'd5:    char_nxt = 7'h20;
            4'd6:    char_nxt = 7'h30 + {3'b000, bcd_q[15:12]};
            4'd7:    char_nxt = 7'h2E;
            4'd8:    char_nxt = 7'h30 + {3'b000, bcd_q[11:8]};
            4'd9:    char_nxt = 7'h30 + {3'b000, bcd_q[7:4]};
            4'd10:   char_nxt = 7'h30 + {3'b000, bcd_q[3:0]};
            default: char_nxt = 7'h56;
        endcase
`ifdef VGA_TEXT_OVR_EN
        if (ovr_q && (col_q == 4'd6 || col_q == 4'd8 || col_q == 4'd9 || col_q == 4'd10)) begin
            char_nxt = 7'h2D;
        end
`endif

        if (rise && state_q != S_IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rise || pending_q) begin
                    state_d   = S_FETCH;
                    pending_d = 1'b0;
                    ch_req_d  = 1'b1;
                    ch_sel_d  = row_q;
                    busy_d    = 1'b1;
                end
            end
            S_FETCH: begin
                if (ch_ack) begin
                    state_d   = S_CONVERT;
                    ch_req_d  = 1'b0;
                    val_d     = (ch_value > VMAX) ? VMAX : ch_value;
`ifdef VGA_TEXT_OVR_EN
                    ovr_d     = (ch_value > VMAX);
`endif
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    col_d     = '0;
                    tens_d    = '0;
                    ones_d    = row_q;
                end
            end
            S_CONVERT: begin
                bcd_d     = {bcd_adj[14:0], val_q[13]};
                val_d     = {val_q[12:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (ones_q >= 4'd10) begin
                    ones_d = ones_q - 4'd10;
                    tens_d = tens_q + 4'd1;
                end
                // Column 0 is a constant, so the first write leaves with the last shift.
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = S_WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = row_base;
                    wr_data_d = char_nxt;
                    col_d     = 4'd1;
                end
            end
            S_WRITE: begin
                if (col_q == NCOLS) begin
                    if (row_q == LAST_ROW) begin
                        state_d      = S_DONE;
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                    end else begin
                        state_d  = S_FETCH;
                        row_d    = row_q + 4'd1;
                        ch_req_d = 1'b1;
                        ch_sel_d = row_q + 4'd1;
                    end
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = row_base + {4'b0000, col_q};
                    wr_data_d = char_nxt;
                    col_d     = col_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                row_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vblnk_prev_q <= 1'b0;
            pending_q    <= 1'b0;
            row_q        <= '0;
            val_q        <= '0;
            bcd_q        <= '0;
            bit_cnt_q    <= '0;
            col_q        <= '0;
            tens_q       <= '0;
            ones_q       <= '0;
            ch_sel_q     <= '0;
            ch_req_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef VGA_TEXT_OVR_EN
            ovr_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            vblnk_prev_q <= vblnk_prev_d;
            pending_q    <= pending_d;
            row_q        <= row_d;
            val_q        <= val_d;
            bcd_q        <= bcd_d;
            bit_cnt_q    <= bit_cnt_d;
            col_q        <= col_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            ch_sel_q     <= ch_sel_d;
            ch_req_q     <= ch_req_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef VGA_TEXT_OVR_EN
            ovr_q        <= ovr_d;
`endif
        end
    end

    assign ch_sel     = ch_sel_q;
    assign ch_req     = ch_req_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
